// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port 32-bit arbiter onto a 16-bit async SRAM; optional SRAM_ARB_FIXED_PRIO_EN
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_p0_vld,
    output logic              o_p0_rdy,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [31:0]       i_p0_wdata,
    input  logic [3:0]        i_p0_bmask,
    output logic              o_p0_rsp_vld,
    input  logic              i_p1_vld,
    output logic              o_p1_rdy,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [31:0]       i_p1_wdata,
    input  logic [3:0]        i_p1_bmask,
    output logic              o_p1_rsp_vld,
    output logic [31:0]       o_rsp_rdata,
    output logic [ADDR_W-2:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RSP} state_t;

    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, port_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [31:0]         wdata_q, buf_q, rdata_q;
    logic [3:0]          bmask_q;
    logic                grant0, grant1, hs, is_idle;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_wdata;
    logic [3:0]          req_bmask;
    logic                in_phase, hi_half, hold_cyc, sample_cyc;
    logic                dq_oe;
    logic [15:0]         dq_out;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^{i_p0_addr[1:0], i_p1_addr[1:0]};
    assign is_idle = (state_q == S_IDLE);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Port 0 wins every tie; no fairness state is kept.
    always_comb begin
        grant0 = is_idle & i_p0_vld;
        grant1 = is_idle & i_p1_vld & ~i_p0_vld;
    end
`else
    logic last_q;

    // Ties go to the port opposite the last granted one (last_q=1 means port 1).
    always_comb begin
        grant0 = is_idle & i_p0_vld & (~i_p1_vld | last_q);
        grant1 = is_idle & i_p1_vld & (~i_p0_vld | ~last_q);
    end

    // Remember who was granted last; reset value makes port 0 win the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) last_q <= 1'b1;
        else if (hs)  last_q <= grant1;
    end
`endif

    assign hs        = grant0 | grant1;
    assign o_p0_rdy  = grant0;
    assign o_p1_rdy  = grant1;
    assign req_we    = grant1 ? i_p1_we    : i_p0_we;
    assign req_addr  = grant1 ? i_p1_addr  : i_p0_addr;
    assign req_wdata = grant1 ? i_p1_wdata : i_p0_wdata;
    assign req_bmask = grant1 ? i_p1_bmask : i_p0_bmask;

    assign in_phase   = (state_q == S_LO) || (state_q == S_HI);
    assign hi_half    = (state_q == S_HI);
    assign hold_cyc   = (cnt_q == WC);
    assign sample_cyc = (cnt_q == WC - 3'd1);

    // Sequencing: writes skip halves whose byte enables are all clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    cnt_d = '0;
                    if (!req_we || (|req_bmask[1:0])) state_d = S_LO;
                    else if (|req_bmask[3:2])         state_d = S_HI;
                    else                              state_d = S_RSP;
                end
            end
            S_LO: begin
                if (hold_cyc) begin
                    cnt_d   = '0;
                    state_d = (!we_q || (|bmask_q[3:2])) ? S_HI : S_RSP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HI: begin
                if (hold_cyc) begin
                    cnt_d   = '0;
                    state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched request and read-data capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bmask_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hs) begin
                we_q    <= req_we;
                port_q  <= grant1;
                addr_q  <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
                bmask_q <= req_bmask;
            end
            if (in_phase && !we_q && sample_cyc) begin
                if (hi_half) buf_q[31:16] <= SRAM_DQ;
                else         buf_q[15:0]  <= SRAM_DQ;
            end
            // Publish the whole word as RSP is entered so it is valid with rsp_vld.
            if (hi_half && !we_q && hold_cyc) rdata_q <= buf_q;
        end
    end

    // SRAM pin drive: strobe low for WAIT_CYCLES, then one hold cycle.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        if (in_phase) begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = {addr_q, hi_half};
            if (we_q) begin
                SRAM_WE_N = hold_cyc;
                dq_oe     = 1'b1;
                dq_out    = hi_half ? wdata_q[31:16] : wdata_q[15:0];
                SRAM_LB_N = ~(hi_half ? bmask_q[2] : bmask_q[0]);
                SRAM_UB_N = ~(hi_half ? bmask_q[3] : bmask_q[1]);
            end else begin
                SRAM_OE_N = hold_cyc;
                SRAM_LB_N = 1'b0;
                SRAM_UB_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ      = dq_oe ? dq_out : 16'hzzzz;
    assign o_rsp_rdata  = rdata_q;
    assign o_p0_rsp_vld = (state_q == S_RSP) & ~port_q;
    assign o_p1_rsp_vld = (state_q == S_RSP) &  port_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized self-checking bench for sram_arbiter with SRAM and word-level reference models
module tb_sram_arbiter;

    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld   [2];
    logic        we    [2];
    logic [18:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  bmask [2];
    logic        rdy0, rdy1, rv0, rv1;
    logic [31:0] rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(19)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_vld(vld[0]), .o_p0_rdy(rdy0), .i_p0_we(we[0]), .i_p0_addr(addr[0]),
        .i_p0_wdata(wdata[0]), .i_p0_bmask(bmask[0]), .o_p0_rsp_vld(rv0),
        .i_p1_vld(vld[1]), .o_p1_rdy(rdy1), .i_p1_we(we[1]), .i_p1_addr(addr[1]),
        .i_p1_wdata(wdata[1]), .i_p1_bmask(bmask[1]), .o_p1_rsp_vld(rv1),
        .o_rsp_rdata(rdata), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    // Async SRAM: drives DQ while read-enabled, stores byte lanes mid-cycle while WE_N is low.
    logic [15:0] sram_mem [0:511];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[8:0]] : 16'hzzzz;
    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr[8:0]][7:0]  = sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr[8:0]][15:8] = sram_dq[15:8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: memory of 32-bit words plus one transaction in flight.
    logic [31:0] ref_mem [0:255];
    int          cyc = 0, t_hs = 0, rsp_at = 0, nh = 0, we_low = 0, oe_low = 0;
    logic        busy = 1'b0, last_port = 1'b1, tx_port, tx_we, lo_skip;
    logic [18:0] tx_addr;
    logic [31:0] tx_wdata, last_rdata = '0;
    logic [3:0]  tx_bmask;
    logic [1:0]  eg;
    int          p;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy       = 1'b0;
            last_port  = 1'b1;
            last_rdata = '0;
        end else begin
            cyc++;
            if (busy) begin
                check("rdy_while_busy", {rdy1, rdy0}, 2'b00);
                if (cyc == rsp_at) begin
                    check("ce_in_rsp", ce_n, 1'b1);
                    check("rsp_port", {rv1, rv0}, tx_port ? 2'b10 : 2'b01);
                    check("we_low_cycles", we_low, tx_we ? WC * nh : 0);
                    check("oe_low_cycles", oe_low, tx_we ? 0 : 2 * WC);
                    if (tx_we) begin
                        for (int b = 0; b < 4; b++)
                            if (tx_bmask[b]) ref_mem[tx_addr[9:2]][8*b +: 8] = tx_wdata[8*b +: 8];
                        check("rdata_after_write", rdata, last_rdata);
                    end else begin
                        last_rdata = ref_mem[tx_addr[9:2]];
                        check("read_data", rdata, last_rdata);
                    end
                    busy = 1'b0;
                end else begin
                    check("ce_in_phase", ce_n, 1'b0);
                    check("rsp_early", {rv1, rv0}, 2'b00);
                    check("sram_addr_word", sram_addr[17:1], tx_addr[18:2]);
                    check("sram_addr_half", sram_addr[0], lo_skip ? 1'b1 : ((cyc - t_hs - 1) >= WC + 1));
                    if (!we_n) we_low++;
                    if (!oe_n) oe_low++;
                end
            end else begin
                check("rsp_when_idle", {rv1, rv0}, 2'b00);
                check("ce_when_idle", ce_n, 1'b1);
                check("rdata_held", rdata, last_rdata);
`ifdef SRAM_ARB_FIXED_PRIO_EN
                eg = vld[0] ? 2'b01 : (vld[1] ? 2'b10 : 2'b00);
`else
                if (vld[0] && vld[1]) eg = last_port ? 2'b01 : 2'b10;
                else                  eg = {vld[1], vld[0]};
`endif
                check("grant", {rdy1, rdy0}, eg);
                if (eg != 2'b00) begin
                    p         = eg[1] ? 1 : 0;
                    tx_port   = eg[1];
                    tx_we     = we[p];
                    tx_addr   = addr[p];
                    tx_wdata  = wdata[p];
                    tx_bmask  = bmask[p];
                    nh        = tx_we ? (int'(|tx_bmask[1:0]) + int'(|tx_bmask[3:2])) : 2;
                    lo_skip   = tx_we && !(|tx_bmask[1:0]);
                    t_hs      = cyc;
                    rsp_at    = cyc + 1 + (WC + 1) * nh;
                    we_low    = 0;
                    oe_low    = 0;
                    last_port = eg[1];
                    busy      = 1'b1;
                end
            end
        end
    end

    // Present a request at posedge+1, hold until accepted, release after the handshake edge.
    task automatic issue(input int port, input logic w, input logic [18:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        logic r;
        vld[port] = 1'b1; we[port] = w; addr[port] = a; wdata[port] = d; bmask[port] = m;
        do begin
            @(negedge clk);
            n++;
            r = (port == 0) ? rdy0 : rdy1;
        end while (!r && n < 300);
        if (!r) check("request_timeout", r, 1'b1);
        @(posedge clk);
        #1;
        vld[port] = 1'b0;
    endtask

    task automatic settle();
        repeat (2 * (WC + 1) + 3) @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] rand_addr();
        return 19'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) sram_mem[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; bmask[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ce_n", ce_n, 1'b1);
        check("reset_we_n", we_n, 1'b1);
        check("reset_oe_lb_ub", {oe_n, lb_n, ub_n}, 3'b111);
        check("reset_sram_addr", sram_addr, 18'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_dq_z", sram_dq === 16'hzzzz, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 1'b1, 19'h00010, 32'hDEADBEEF, 4'hF);
        issue(0, 1'b0, 19'h00010, 32'h0, 4'h0);
        settle();
        check("word_readback", rdata, 32'hDEADBEEF);

        issue(0, 1'b1, 19'h00020, 32'hAAAAAAAA, 4'hF);
        issue(0, 1'b1, 19'h00020, 32'h12345678, 4'hC);
        issue(0, 1'b0, 19'h00020, 32'h0, 4'h0);
        settle();
        check("upper_half_write", rdata, 32'h1234AAAA);
        issue(1, 1'b1, 19'h00024, 32'hFFFFFFFF, 4'h0);
        settle();

        // Abort a write during its HI strobe; only the LO half reaches the SRAM.
        issue(0, 1'b1, 19'h00030, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("hi_strobe_before_reset", we_n, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_we_n", we_n, 1'b1);
        check("abort_ce_n", ce_n, 1'b1);
        check("abort_dq_z", sram_dq === 16'hzzzz, 1'b1);
        ref_mem[8'h0C][15:0] = 16'hF00D;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        issue(0, 1'b0, 19'h00030, 32'h0, 4'h0);
        settle();
        check("aborted_write_lo_only", rdata, 32'h0000F00D);

        // Both ports requesting back to back.
        fork
            begin
                for (int i = 0; i < 6; i++) issue(0, 1'b0, rand_addr(), 32'h0, 4'h0);
            end
            begin
                for (int j = 0; j < 6; j++) issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
            end
        join
        settle();

        // Random traffic with idle gaps.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
                end
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
                end
            end
        join
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
